ahbl2apb_bridge: RTL

AHBL2APB_BRIDGE -- requirements
Module: ahbl2apb_bridge

---
 rtl/ahbl2apb_bridge.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ahbl2apb_bridge.sv
// AHB-Lite to APB bridge with programmable APB clock-enable divider.
// Optional macro AHBL2APB_ERR_RESP_EN: map pslverr to a two-cycle AHB ERROR response.
module ahbl2apb_bridge (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hsel,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   output logic [31:0] hrdata,
   output logic        hready,
   output logic        hresp,
   input  logic [3:0]  clk_ratio,
   output logic        pclken,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_SETUP  = 3'd2;
   localparam logic [2:0] S_ACCESS = 3'd3;
`ifdef AHBL2APB_ERR_RESP_EN
   localparam logic [2:0] S_ERR1   = 3'd4;
   localparam logic [2:0] S_ERR2   = 3'd5;
`endif

   logic [2:0]  r_state;
   logic [3:0]  r_cnt;
   logic [3:0]  r_lim;
   logic [31:0] r_addr;
   logic        r_write;
   logic [31:0] r_hrdata;
   logic        r_hready;
   logic        r_hresp;
   logic [31:0] r_paddr;
   logic [31:0] r_pwdata;
   logic        r_psel;
   logic        r_penable;
   logic        r_pwrite;

   logic [3:0]  w_lim;
   logic        w_pclken;
   logic        w_valid;
   logic        w_unused;

   // ratio 0 behaves as 1; limit is the last count value before wrap
   assign w_lim    = (clk_ratio == 4'd0) ? 4'd0 : clk_ratio - 4'd1;
   assign w_pclken = (r_cnt == 4'd0);
   // NONSEQ/SEQ only; hready low blocks new address phases while busy
   assign w_valid  = hsel & r_hready & htrans[1];
   assign w_unused = ^{hsize, hburst, hprot, htrans[0], pslverr};

   assign pclken  = w_pclken;
   assign hrdata  = r_hrdata;
   assign hready  = r_hready;
   assign hresp   = r_hresp;
   assign paddr   = r_paddr;
   assign pwdata  = r_pwdata;
   assign psel    = r_psel;
   assign penable = r_penable;
   assign pwrite  = r_pwrite;

   // Divider: new ratio is latched only at wrap so the current period always completes
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         r_cnt <= 4'd0;
         r_lim <= w_lim;
      end else if (r_cnt >= r_lim) begin
         r_cnt <= 4'd0;
         r_lim <= w_lim;
      end else begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   // Transfer FSM: AHB capture, APB setup/access sequencing, response
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         r_state   <= S_IDLE;
         r_addr    <= 32'd0;
         r_write   <= 1'b0;
         r_hrdata  <= 32'd0;
         r_hready  <= 1'b1;
         r_hresp   <= 1'b0;
         r_paddr   <= 32'd0;
         r_pwdata  <= 32'd0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  r_addr   <= haddr;
                  r_write  <= hwrite;
                  r_hready <= 1'b0;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_pclken) begin
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
                  r_paddr   <= r_addr;
                  r_pwrite  <= r_write;
                  r_pwdata  <= hwdata;
                  r_state   <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (w_pclken) begin
                  r_penable <= 1'b1;
                  r_state   <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (w_pclken && pready) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
`ifdef AHBL2APB_ERR_RESP_EN
                  if (pslverr) begin
                     r_hresp <= 1'b1;
                     r_state <= S_ERR1;
                  end else begin
                     if (!r_pwrite) r_hrdata <= prdata;
                     r_hready <= 1'b1;
                     r_hresp  <= 1'b0;
                     r_state  <= S_IDLE;
                  end
`else
                  if (!r_pwrite) r_hrdata <= prdata;
                  r_hready <= 1'b1;
                  r_hresp  <= 1'b0;
                  r_state  <= S_IDLE;
`endif
               end
            end
`ifdef AHBL2APB_ERR_RESP_EN
            S_ERR1: begin
               r_hready <= 1'b1;
               r_state  <= S_ERR2;
            end
            S_ERR2: begin
               r_hresp <= 1'b0;
               if (w_valid) begin
                  r_addr   <= haddr;
                  r_write  <= hwrite;
                  r_hready <= 1'b0;
                  r_state  <= S_WAIT;
               end else begin
                  r_state  <= S_IDLE;
               end
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
